// File: rtl/fifo_ctrl_param_if.sv
// Push/pop handshake, thresholds and status bundle for one fifo_ctrl_param channel.
// The producer side uses the master modport; the FIFO itself uses slave.
interface fifo_ctrl_param_if #(
  parameter int unsigned WORD_SIZE = 6,
  parameter int unsigned PTR_L     = 2
) ();

  logic [WORD_SIZE-1:0] data_in;
  logic                 push;
  logic                 pop;
  logic [PTR_L:0]       th_almost_full;
  logic [PTR_L:0]       th_almost_empty;

  logic [WORD_SIZE-1:0] data_out;
  logic                 valid;
  logic [PTR_L:0]       fifo_count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output data_in,
    output push,
    output pop,
    output th_almost_full,
    output th_almost_empty,
    input  data_out,
    input  valid,
    input  fifo_count,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  data_in,
    input  push,
    input  pop,
    input  th_almost_full,
    input  th_almost_empty,
    output data_out,
    output valid,
    output fifo_count,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO with internal pointers, occupancy count, threshold flags,
// sticky overflow/underflow and a one-cycle registered read port with valid strobe.
module fifo_ctrl_param #(
  parameter int unsigned MEM_SIZE  = 4,
  parameter int unsigned WORD_SIZE = 6,
  parameter int unsigned PTR_L     = 2
) (
  input  logic             clk,
  input  logic             reset,
  fifo_ctrl_param_if.slave bus
);

  typedef logic [PTR_L-1:0]     ptr_t;
  typedef logic [PTR_L:0]       cnt_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  localparam cnt_t FullCount = cnt_t'(MEM_SIZE);

  // Storage is never reset; only the pointers and count define what is live.
  word_t mem_q [MEM_SIZE];

  ptr_t  wr_ptr_q,    wr_ptr_d;
  ptr_t  rd_ptr_q,    rd_ptr_d;
  cnt_t  count_q,     count_d;
  word_t data_out_q,  data_out_d;
  logic  valid_q,     valid_d;
  logic  overflow_q,  overflow_d;
  logic  underflow_q, underflow_d;

  logic full, empty;
  logic push_ok, pop_ok;

  // Status decodes of registered count plus live thresholds.
  always_comb begin
    full    = (count_q == FullCount);
    empty   = (count_q == '0);
    push_ok = bus.push & (~full | bus.pop);
    pop_ok  = bus.pop & ~empty;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q | (bus.push & full & ~bus.pop);
    underflow_d = underflow_q | (bus.pop & empty);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      // Reads the pre-edge memory, so push+pop at full returns the oldest word.
      data_out_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
      valid_d    = 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid        = valid_q;
  assign bus.fifo_count   = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= bus.th_almost_full);
  assign bus.almost_empty = (count_q <= bus.th_almost_empty);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed bench for fifo_ctrl_param: a vector table for fill/drain/wrap/threshold cases
// plus hand sequences for the held reset and the asynchronous mid-operation reset.
module tb_fifo_ctrl_param;

  localparam int unsigned WS = 6;
  localparam int unsigned PL = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  fifo_ctrl_param_if #(.WORD_SIZE(WS), .PTR_L(PL)) bus ();

  fifo_ctrl_param #(
    .MEM_SIZE (4),
    .WORD_SIZE(WS),
    .PTR_L    (PL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       push;
    logic       pop;
    logic [5:0] din;
    logic [2:0] taf;
    logic [2:0] tae;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       vld;
    logic [5:0] dout;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic push, logic pop, logic [5:0] din,
                              logic [2:0] taf, logic [2:0] tae, logic [2:0] cnt,
                              logic full, logic empty, logic af, logic ae, logic vld,
                              logic [5:0] dout, logic ovf, logic udf);
    vec_t v;
    v.rst = rst;   v.push = push;   v.pop = pop;   v.din = din;
    v.taf = taf;   v.tae = tae;     v.cnt = cnt;   v.full = full;
    v.empty = empty; v.af = af;     v.ae = ae;     v.vld = vld;
    v.dout = dout; v.ovf = ovf;     v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] cnt, input logic full,
                         input logic empty, input logic af, input logic ae, input logic vld,
                         input logic [5:0] dout, input logic ovf, input logic udf);
    chk({tag, ".count"},        32'(bus.fifo_count),   32'(cnt));
    chk({tag, ".full"},         32'(bus.full),         32'(full));
    chk({tag, ".empty"},        32'(bus.empty),        32'(empty));
    chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(af));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
    chk({tag, ".valid"},        32'(bus.valid),        32'(vld));
    chk({tag, ".data_out"},     32'(bus.data_out),     32'(dout));
    chk({tag, ".overflow"},     32'(bus.overflow),     32'(ovf));
    chk({tag, ".underflow"},    32'(bus.underflow),    32'(udf));
  endtask

  task automatic step(input logic push, input logic pop, input logic [5:0] din);
    @(negedge clk);
    bus.push    = push;
    bus.pop     = pop;
    bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    bus.push            = 1'b0;
    bus.pop             = 1'b0;
    bus.data_in         = '0;
    bus.th_almost_full  = 3'd3;
    bus.th_almost_empty = 3'd1;

    repeat (5) @(posedge clk);
    #1;
    chk_all("reset_hold", 3'd0, 0, 1, 0, 1, 0, 6'h00, 0, 0);

    //            rst psh pop din    taf tae cnt  f  e  af ae v  dout   o  u
    // Fill, overflow, drain, underflow.
    vecs.push_back(mk(0, 1, 0, 6'h11, 3, 1, 3'd1, 0, 0, 0, 1, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h22, 3, 1, 3'd2, 0, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h33, 3, 1, 3'd3, 0, 0, 1, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h04, 3, 1, 3'd4, 1, 0, 1, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h3F, 3, 1, 3'd4, 1, 0, 1, 0, 0, 6'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd3, 0, 0, 1, 0, 1, 6'h11, 1, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd2, 0, 0, 0, 0, 1, 6'h22, 1, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd1, 0, 0, 0, 1, 1, 6'h33, 1, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd0, 0, 1, 0, 1, 1, 6'h04, 1, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd0, 0, 1, 0, 1, 0, 6'h04, 1, 1));
    // Synchronous-looking reset to clear sticky flags, then wrap with simultaneous ops.
    vecs.push_back(mk(1, 0, 0, 6'h00, 3, 1, 3'd0, 0, 1, 0, 1, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h01, 3, 1, 3'd1, 0, 0, 0, 1, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h02, 3, 1, 3'd2, 0, 0, 0, 0, 0, 6'h00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h03, 3, 1, 3'd2, 0, 0, 0, 0, 1, 6'h01, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h04, 3, 1, 3'd3, 0, 0, 1, 0, 0, 6'h01, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h05, 3, 1, 3'd4, 1, 0, 1, 0, 0, 6'h01, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h06, 3, 1, 3'd4, 1, 0, 1, 0, 1, 6'h02, 0, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd3, 0, 0, 1, 0, 1, 6'h03, 0, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd2, 0, 0, 0, 0, 1, 6'h04, 0, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd1, 0, 0, 0, 1, 1, 6'h05, 0, 0));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd0, 0, 1, 0, 1, 1, 6'h06, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h07, 3, 1, 3'd1, 0, 0, 0, 1, 0, 6'h06, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 3, 1, 3'd0, 0, 1, 0, 1, 1, 6'h07, 0, 1));
    // Threshold corners: zero, above depth, and live changes.
    vecs.push_back(mk(0, 0, 0, 6'h00, 0, 0, 3'd0, 0, 1, 1, 1, 0, 6'h07, 0, 1));
    vecs.push_back(mk(0, 0, 0, 6'h00, 7, 5, 3'd0, 0, 1, 0, 1, 0, 6'h07, 0, 1));
    vecs.push_back(mk(0, 1, 0, 6'h08, 1, 0, 3'd1, 0, 0, 1, 0, 0, 6'h07, 0, 1));
    vecs.push_back(mk(0, 0, 1, 6'h00, 5, 5, 3'd0, 0, 1, 0, 1, 1, 6'h08, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset               = vecs[i].rst;
      bus.push            = vecs[i].push;
      bus.pop             = vecs[i].pop;
      bus.data_in         = vecs[i].din;
      bus.th_almost_full  = vecs[i].taf;
      bus.th_almost_empty = vecs[i].tae;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].af,
              vecs[i].ae, vecs[i].vld, vecs[i].dout, vecs[i].ovf, vecs[i].udf);
    end

    // Mid-operation asynchronous reset with count=3 and overflow set.
    @(negedge clk);
    reset               = 1'b0;
    bus.th_almost_full  = 3'd3;
    bus.th_almost_empty = 3'd1;
    step(1, 0, 6'h10);
    step(1, 0, 6'h20);
    step(1, 0, 6'h30);
    step(1, 0, 6'h05);
    step(1, 0, 6'h3F);
    step(0, 1, 6'h00);
    chk("pre_rst.count",    32'(bus.fifo_count), 32'd3);
    chk("pre_rst.overflow", 32'(bus.overflow),   32'd1);
    chk("pre_rst.valid",    32'(bus.valid),      32'd1);
    chk("pre_rst.data_out", 32'(bus.data_out),   32'h10);

    @(negedge clk);
    bus.pop = 1'b0;
    bus.push = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 0, 1, 0, 1, 0, 6'h00, 0, 0);
    #1 reset = 1'b0;

    step(1, 0, 6'h2A);
    chk("post_rst_push.count", 32'(bus.fifo_count), 32'd1);
    step(0, 1, 6'h00);
    chk("post_rst_pop.data_out", 32'(bus.data_out), 32'h2A);
    chk("post_rst_pop.valid",    32'(bus.valid),    32'd1);
    chk("post_rst_pop.empty",    32'(bus.empty),    32'd1);
    step(0, 0, 6'h00);
    chk("post_rst_idle.valid",    32'(bus.valid),    32'd0);
    chk("post_rst_idle.data_out", 32'(bus.data_out), 32'h2A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
